fifo_fwft_prog: RTL
===================

# fifo_fwft_prog

Parametrised first-word-fall-through synchronous FIFO, next generation of the team's FWFT FIFO. It adds:
- programmable almost-full and almost-empty thresholds;
- a synchronous flush;
- full-rate back-to-back reads with no bubbles;
- optional sticky overflow/underflow error flags.

It sits between producer and consumer datapaths in one clock domain.

## Interface
- DATA_WIDTH, 8, word width in bits (≥1)
- DEPTH_WIDTH, 4, log2 of capacity; capacity CAP = 2**DEPTH_WIDTH words (≥2)
- AFULL_THRESH, CAP-2, almost_full asserts when cnt ≥ this (1..CAP)
- AEMPTY_THRESH, 1, almost_empty asserts when cnt ≤ this (0..CAP-1)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous assert, active-high
- flush  in  1  synchronous clear of all contents
- din  in  DATA_WIDTH  write data
- wr_en  in  1  write request
- full  out  1  cnt == CAP
- almost_full  out  1  cnt ≥ AFULL_THRESH
- dout  out  DATA_WIDTH  head word, valid while empty low
- rd_en  in  1  pop head word
- empty  out  1  no word presented on dout
- almost_empty  out  1  cnt ≤ AEMPTY_THRESH
- cnt  out  DEPTH_WIDTH+1  total words held, including prefetch stages
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

## Operation
- **Storage:** CAP-entry RAM with registered read, followed by a prefetch/output register pair. Words fall through to dout automatically.
- **cnt:** counts every accepted, unpopped word wherever it is held. It never exceeds CAP.
- **Write:** accepted iff wr_en && !full (full sampled before the edge). A write while full is dropped, even if rd_en is high the same cycle.
- **Read:** accepted iff rd_en && !empty. A read while empty is ignored and does not block a same-cycle write.
- **Simultaneous accepted read and write:** cnt unchanged.
- **Pointers:** wrap modulo CAP. Order is strictly preserved.
- **Flush:** has priority over wr_en and rd_en that cycle. It empties all stages and resets pointers and cnt to 0, but does not clear overflow or underflow.
- **Reset:** async rst clears everything. Mid-operation reset discards all contents.

## Timing
- **Reset values:** empty=1, full=0, almost_empty=1, almost_full=0 (AFULL_THRESH ≥ 1), cnt=0, overflow=0, underflow=0. dout is all zeros.
- **cnt:** registered. It updates on the edge that accepts the access.
- **full / almost_full / almost_empty:** decoded from registered cnt; no combinational path from inputs.
- **Write-to-read latency:** a word written at edge k into an empty FIFO gives empty=0 and dout valid after edge k+2.
- **Read throughput:** with ≥2 words already fallen through, continuous rd_en pops one word per clock with no bubble.
- **dout after a pop:** dout changes only on an edge that pops or fills the output stage. It holds otherwise.

## Configuration
- FIFO_FWFT_PROG_ERR_FLAGS_EN defined:
  - overflow sets on wr_en && full.
  - underflow sets on rd_en && empty.
  - Both stay set until rst.
- Not defined: overflow and underflow are tied to 0 and no flag flops are built. Ports remain so instantiations are unchanged.

## Structure
- Shared package fifo_fwft_prog_pkg:
  - function computing CAP from DEPTH_WIDTH;
  - default threshold constants;
  - elaboration-time parameter range checks.
- Sub-module fifo_fwft_prog_ram: simple dual-port RAM, one write port and one registered read port, DATA_WIDTH × CAP. No reset on the array.
- Top level holds:
  - pointers;
  - cnt;
  - the prefetch/output valid flags and registers;
  - flags.

## Test plan
All scenarios use DATA_WIDTH=8, DEPTH_WIDTH=2 (CAP=4), AFULL_THRESH=3, AEMPTY_THRESH=1.
- **Fall-through:** reset, write 0xA5 at edge k.
  - Required: empty=0 and dout=0xA5 after edge k+2.
  - Required: cnt=1, almost_empty=1.
- **Fill and flags:** write 0x01..0x04 on consecutive edges.
  - Required: almost_full=1 at cnt=3; full=1 at cnt=4.
  - A fifth write of 0x05 is dropped; overflow=1 with the macro, 0 without.
- **Back-to-back read:** from full, hold rd_en for 4 edges.
  - Required: dout sequence 0x01,0x02,0x03,0x04 on consecutive cycles.
  - Required: then empty=1, cnt=0.
  - A further rd_en sets underflow (macro defined).
- **Simultaneous access:** at cnt=2, assert wr_en and rd_en together for 6 edges with incrementing data.
  - Required: cnt stays 2 and order is preserved across pointer wrap.
- **Flush:** at cnt=3, assert flush together with wr_en=1.
  - Required: next edge gives cnt=0, empty=1, and the write is discarded.
  - Required: the following write reappears after 2 edges.
- **Async reset:** assert rst mid-cycle at cnt=2 (not on an edge).
  - Required: empty=1, cnt=0, overflow=0 immediately, without waiting for an edge.

Source files
------------

// File: rtl/fifo_fwft_prog_pkg.sv
// ============================================================================
// Module   : fifo_fwft_prog_pkg
// Brief    : Shared constants, capacity helper and parameter checks for
//            fifo_fwft_prog.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fifo_fwft_prog_pkg;

  localparam int c_def_data_width   = 8;
  localparam int c_def_depth_width  = 4;
  localparam int c_def_afull_margin = 2;
  localparam int c_def_aempty_thr   = 1;

  function automatic int fifo_cap(input int depth_width);
    return 1 << depth_width;
  endfunction

  function automatic bit params_ok(input int data_width, input int depth_width,
                                   input int afull_thr, input int aempty_thr);
    int cap;
    cap = fifo_cap(depth_width);
    return (data_width >= 1) && (depth_width >= 1) &&
           (afull_thr >= 1) && (afull_thr <= cap) &&
           (aempty_thr >= 0) && (aempty_thr <= cap - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_fwft_prog_ram.sv
// ============================================================================
// Module   : fifo_fwft_prog_ram
// Brief    : Simple dual-port RAM, one write port and one registered read
//            port. The array carries no reset.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_fwft_prog_ram
  import fifo_fwft_prog_pkg::*;
#(
  parameter int DATA_WIDTH  = c_def_data_width,
  parameter int DEPTH_WIDTH = c_def_depth_width
) (
  input  logic                   clk,
  input  logic                   we_i,
  input  logic [DEPTH_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0]  wdata_i,
  input  logic                   re_i,
  input  logic [DEPTH_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0]  rdata_o
);

  localparam int c_cap = fifo_cap(DEPTH_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [0:c_cap-1];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Read data register holds its value whenever re_i is low.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/fifo_fwft_prog.sv
// ============================================================================
// Module   : fifo_fwft_prog
// Brief    : First-word-fall-through synchronous FIFO with programmable
//            almost-full/almost-empty thresholds, synchronous flush and
//            optional sticky error flags (FIFO_FWFT_PROG_ERR_FLAGS_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_fwft_prog
  import fifo_fwft_prog_pkg::*;
#(
  parameter int DATA_WIDTH    = c_def_data_width,
  parameter int DEPTH_WIDTH   = c_def_depth_width,
  parameter int AFULL_THRESH  = fifo_cap(DEPTH_WIDTH) - c_def_afull_margin,
  parameter int AEMPTY_THRESH = c_def_aempty_thr
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [DATA_WIDTH-1:0]  din,
  input  logic                   wr_en,
  output logic                   full,
  output logic                   almost_full,
  output logic [DATA_WIDTH-1:0]  dout,
  input  logic                   rd_en,
  output logic                   empty,
  output logic                   almost_empty,
  output logic [DEPTH_WIDTH:0]   cnt,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int                 c_cap      = fifo_cap(DEPTH_WIDTH);
  localparam logic [DEPTH_WIDTH:0] c_cnt_cap  = (DEPTH_WIDTH+1)'(c_cap);
  localparam logic [DEPTH_WIDTH:0] c_afull    = (DEPTH_WIDTH+1)'(AFULL_THRESH);
  localparam logic [DEPTH_WIDTH:0] c_aempty   = (DEPTH_WIDTH+1)'(AEMPTY_THRESH);

  if (!params_ok(DATA_WIDTH, DEPTH_WIDTH, AFULL_THRESH, AEMPTY_THRESH)) begin : g_param_check
    $error("fifo_fwft_prog: parameter out of range");
  end

  logic [DEPTH_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_WIDTH:0]   cnt_q, cnt_d;
  logic                   s1_valid_q, s1_valid_d;
  logic                   s1_byp_q, s1_byp_d;
  logic [DATA_WIDTH-1:0]  byp_data_q, byp_data_d;
  logic                   out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;

  logic                   w_full;
  logic                   w_wr_acc;
  logic                   w_rd_acc;
  logic                   w_out_load;
  logic                   w_s1_free;
  logic [DEPTH_WIDTH:0]   w_ram_cnt;
  logic                   w_ram_has;
  logic                   w_ram_re;
  logic                   w_ram_we;
  logic                   w_bypass;
  logic [DATA_WIDTH-1:0]  w_ram_rdata;
  logic [DATA_WIDTH-1:0]  w_s1_data;

  assign w_full     = (cnt_q == c_cnt_cap);
  assign w_wr_acc   = wr_en && !w_full && !flush;
  assign w_rd_acc   = rd_en && out_valid_q && !flush;
  assign w_out_load = s1_valid_q && (!out_valid_q || w_rd_acc);
  assign w_s1_free  = !s1_valid_q || w_out_load;
  // Words resident in the RAM are whatever cnt holds beyond the two stages.
  assign w_ram_cnt  = cnt_q - (DEPTH_WIDTH+1)'(s1_valid_q) - (DEPTH_WIDTH+1)'(out_valid_q);
  assign w_ram_has  = (w_ram_cnt != '0);
  assign w_ram_re   = w_ram_has && w_s1_free && !flush;
  // Once the output stage is occupied, a write that would be next in line
  // skips the RAM so a steady read+write stream never starves the output.
  assign w_bypass   = w_wr_acc && !w_ram_has && w_s1_free && out_valid_q;
  assign w_ram_we   = w_wr_acc && !w_bypass;
  assign w_s1_data  = s1_byp_q ? byp_data_q : w_ram_rdata;

  fifo_fwft_prog_ram #(
    .DATA_WIDTH  (DATA_WIDTH),
    .DEPTH_WIDTH (DEPTH_WIDTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (w_ram_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (din),
    .re_i    (w_ram_re),
    .raddr_i (rd_ptr_q),
    .rdata_o (w_ram_rdata)
  );

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    s1_valid_d  = s1_valid_q;
    s1_byp_d    = s1_byp_q;
    byp_data_d  = byp_data_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      cnt_d       = '0;
      s1_valid_d  = 1'b0;
      s1_byp_d    = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      cnt_d = cnt_q + (DEPTH_WIDTH+1)'(w_wr_acc) - (DEPTH_WIDTH+1)'(w_rd_acc);
      if (w_ram_we) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (w_ram_re) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (w_out_load) begin
        out_valid_d = 1'b1;
        out_data_d  = w_s1_data;
      end else if (w_rd_acc) begin
        out_valid_d = 1'b0;
      end
      if (w_ram_re) begin
        s1_valid_d = 1'b1;
        s1_byp_d   = 1'b0;
      end else if (w_bypass) begin
        s1_valid_d = 1'b1;
        s1_byp_d   = 1'b1;
        byp_data_d = din;
      end else if (w_out_load) begin
        s1_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_byp_q    <= 1'b0;
      byp_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      s1_valid_q  <= s1_valid_d;
      s1_byp_q    <= s1_byp_d;
      byp_data_q  <= byp_data_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

`ifdef FIFO_FWFT_PROG_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  assign overflow_d  = overflow_q  || (wr_en && w_full);
  assign underflow_d = underflow_q || (rd_en && !out_valid_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  assign full         = w_full;
  assign almost_full  = (cnt_q >= c_afull);
  assign almost_empty = (cnt_q <= c_aempty);
  assign empty        = !out_valid_q;
  assign dout         = out_data_q;
  assign cnt          = cnt_q;

endmodule

`default_nettype wire
